// File: rtl/bn_pkg.sv
// Shared types for the Batalha Naval board manager: cell states, command/response
// codes and the controller state encoding.
package bn_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SHIP  = 2'b01,
    CELL_HIT   = 2'b10,
    CELL_MISS  = 2'b11
  } cell_t;

  localparam logic [1:0] OP_PLACE = 2'b00;
  localparam logic [1:0] OP_SHOOT = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [1:0] RSP_OK     = 2'b00;
  localparam logic [1:0] RSP_REJECT = 2'b01;
  localparam logic [1:0] RSP_MISS   = 2'b10;
  localparam logic [1:0] RSP_HIT    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_SHOT,
    ST_CLR,
    ST_RESP
  } state_t;

endpackage

// File: rtl/tabuleiro_mem.sv
// One player's board: GRID_W x GRID_W flop array of cell_t, row-major (y*GRID_W + x),
// combinational read, single synchronous write, async reset to EMPTY.
module tabuleiro_mem
  import bn_pkg::*;
#(
  parameter int GRID_W = 8,
  localparam int CELLS  = GRID_W * GRID_W,
  localparam int ADDR_W = $clog2(CELLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output cell_t             rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  cell_t             wr_data
);

  cell_t cells [CELLS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) cells[i] <= CELL_EMPTY;
    end else if (we) begin
      cells[wr_addr] <= wr_data;
    end
  end

  assign rd_data = cells[rd_addr];

endmodule

// File: rtl/gerenciador_tabuleiro.sv
// Board manager: placement with collision/bounds checks, shot evaluation, board clear,
// per-player remaining-ship-cell counters and sticky game_over. Optional macro
// BN_REPEAT_REJECT_EN makes a repeat shot answer REJECT instead of the stored outcome.
//
// state    | meaning
// IDLE     | cmd_ready high, decode and pre-check the incoming command
// CHECK    | PLACE: scan ship cells one per cycle, abort on first non-EMPTY
// WRITE    | PLACE: write SHIP one cell per cycle
// SHOT     | SHOOT: read cell and write back HIT/MISS in the same cycle
// CLR      | CLEAR: write EMPTY over the whole board, row-major
// RESP     | one-cycle rsp_valid strobe
module gerenciador_tabuleiro
  import bn_pkg::*;
#(
  parameter int GRID_W       = 8,
  parameter int NUM_PLAYERS  = 2,
  parameter int MAX_SHIP_LEN = 4,
  localparam int COORD_W  = $clog2(GRID_W),
  localparam int PLAYER_W = $clog2(NUM_PLAYERS),
  localparam int LEN_W    = $clog2(MAX_SHIP_LEN + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [PLAYER_W-1:0] cmd_player,
  input  logic [COORD_W-1:0]  cmd_x,
  input  logic [COORD_W-1:0]  cmd_y,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                cmd_dir,
  output logic                rsp_valid,
  output logic [1:0]          rsp_code,
  output logic                rsp_repeat,
  output logic                game_over,
  output logic [PLAYER_W-1:0] loser
);

  localparam int CELLS  = GRID_W * GRID_W;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int CNT_W  = $clog2(CELLS + 1);

`ifdef BN_REPEAT_REJECT_EN
  localparam logic [1:0] REP_HIT_CODE  = RSP_REJECT;
  localparam logic [1:0] REP_MISS_CODE = RSP_REJECT;
`else
  localparam logic [1:0] REP_HIT_CODE  = RSP_HIT;
  localparam logic [1:0] REP_MISS_CODE = RSP_MISS;
`endif

  state_t              state_q;
  logic [PLAYER_W-1:0] player_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   start_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LEN_W-1:0]    len_q;
  logic                dir_q;
  logic [CNT_W-1:0]    remaining [NUM_PLAYERS];

  cell_t               rd_cell [NUM_PLAYERS];
  cell_t               cur_cell;
  logic                mem_we;
  cell_t               mem_wdata;
  logic [ADDR_W-1:0]   step;
  logic [ADDR_W-1:0]   start_addr;
  logic                bad_player, bad_coord, bad_len, bad_end, reject_now;

  assign cur_cell   = rd_cell[player_q];
  assign step       = dir_q ? ADDR_W'(GRID_W) : ADDR_W'(1);
  assign start_addr = ADDR_W'(int'(cmd_y) * GRID_W + int'(cmd_x));

  always_comb begin
    bad_player = int'(cmd_player) >= NUM_PLAYERS;
    bad_coord  = (int'(cmd_x) >= GRID_W) || (int'(cmd_y) >= GRID_W);
    bad_len    = (cmd_len == '0) || (int'(cmd_len) > MAX_SHIP_LEN);
    bad_end    = (int'(cmd_dir ? cmd_y : cmd_x) + int'(cmd_len) - 1) >= GRID_W;
    reject_now = bad_player || (cmd_op == OP_RSVD)
              || ((cmd_op == OP_PLACE) && (bad_len || bad_coord || bad_end))
              || ((cmd_op == OP_SHOOT) && bad_coord)
              || (game_over && (cmd_op != OP_CLEAR));
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = CELL_EMPTY;
    case (state_q)
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = CELL_SHIP;
      end
      ST_SHOT: begin
        if (cur_cell == CELL_EMPTY) begin
          mem_we    = 1'b1;
          mem_wdata = CELL_MISS;
        end else if (cur_cell == CELL_SHIP) begin
          mem_we    = 1'b1;
          mem_wdata = CELL_HIT;
        end
      end
      ST_CLR: mem_we = 1'b1;
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_mem
    tabuleiro_mem #(.GRID_W(GRID_W)) u_mem (
      .clk     (clk),
      .reset   (reset),
      .rd_addr (addr_q),
      .rd_data (rd_cell[g]),
      .we      (mem_we && (int'(player_q) == g)),
      .wr_addr (addr_q),
      .wr_data (mem_wdata)
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_code   <= RSP_OK;
      rsp_repeat <= 1'b0;
      game_over  <= 1'b0;
      loser      <= '0;
      player_q   <= '0;
      addr_q     <= '0;
      start_q    <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      dir_q      <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) remaining[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rsp_valid  <= 1'b0;
          rsp_repeat <= 1'b0;
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            player_q  <= cmd_player;
            addr_q    <= start_addr;
            start_q   <= start_addr;
            len_q     <= cmd_len;
            dir_q     <= cmd_dir;
            cnt_q     <= CNT_W'(cmd_len) - CNT_W'(1);
            if (reject_now) begin
              rsp_code  <= RSP_REJECT;
              rsp_valid <= 1'b1;
              state_q   <= ST_RESP;
            end else if (cmd_op == OP_PLACE) begin
              state_q <= ST_CHECK;
            end else if (cmd_op == OP_SHOOT) begin
              state_q <= ST_SHOT;
            end else begin
              addr_q  <= '0;
              cnt_q   <= CNT_W'(CELLS - 1);
              state_q <= ST_CLR;
            end
          end
        end
        ST_CHECK: begin
          if (cur_cell != CELL_EMPTY) begin
            rsp_code  <= RSP_REJECT;
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
          end else if (cnt_q == '0) begin
            addr_q  <= start_q;
            cnt_q   <= CNT_W'(len_q) - CNT_W'(1);
            state_q <= ST_WRITE;
          end else begin
            addr_q <= addr_q + step;
            cnt_q  <= cnt_q - CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (cnt_q == '0) begin
            remaining[player_q] <= remaining[player_q] + CNT_W'(len_q);
            rsp_code  <= RSP_OK;
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            addr_q <= addr_q + step;
            cnt_q  <= cnt_q - CNT_W'(1);
          end
        end
        ST_SHOT: begin
          rsp_valid <= 1'b1;
          state_q   <= ST_RESP;
          case (cur_cell)
            CELL_EMPTY: rsp_code <= RSP_MISS;
            CELL_SHIP: begin
              rsp_code            <= RSP_HIT;
              remaining[player_q] <= remaining[player_q] - CNT_W'(1);
              // last ship cell of this fleet: flag the loser on this same edge
              if (remaining[player_q] == CNT_W'(1)) begin
                game_over <= 1'b1;
                loser     <= player_q;
              end
            end
            CELL_HIT: begin
              rsp_code   <= REP_HIT_CODE;
              rsp_repeat <= 1'b1;
            end
            default: begin
              rsp_code   <= REP_MISS_CODE;
              rsp_repeat <= 1'b1;
            end
          endcase
        end
        ST_CLR: begin
          if (cnt_q == '0) begin
            remaining[player_q] <= '0;
            game_over <= 1'b0;
            loser     <= '0;
            rsp_code  <= RSP_OK;
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gerenciador_tabuleiro.sv
// Directed, table-driven bench for gerenciador_tabuleiro (8x8, 2 players, ships up to 4),
// plus hand-written reset and mid-command reset sequences.
module tb_gerenciador_tabuleiro;

  localparam int PLAYER_W = 1;
  localparam int COORD_W  = 3;
  localparam int LEN_W    = 3;

`ifdef BN_REPEAT_REJECT_EN
  localparam logic [1:0] EXP_REP_HIT  = 2'b01;
  localparam logic [1:0] EXP_REP_MISS = 2'b01;
`else
  localparam logic [1:0] EXP_REP_HIT  = 2'b11;
  localparam logic [1:0] EXP_REP_MISS = 2'b10;
`endif

  localparam logic [1:0] OK = 2'b00, REJ = 2'b01, MS = 2'b10, HT = 2'b11;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [1:0]          cmd_op = '0;
  logic [PLAYER_W-1:0] cmd_player = '0;
  logic [COORD_W-1:0]  cmd_x = '0;
  logic [COORD_W-1:0]  cmd_y = '0;
  logic [LEN_W-1:0]    cmd_len = '0;
  logic                cmd_dir = 1'b0;
  logic                rsp_valid;
  logic [1:0]          rsp_code;
  logic                rsp_repeat;
  logic                game_over;
  logic [PLAYER_W-1:0] loser;

  int n_cmp = 0;
  int n_err = 0;

  gerenciador_tabuleiro dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_player (cmd_player),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_len    (cmd_len),
    .cmd_dir    (cmd_dir),
    .rsp_valid  (rsp_valid),
    .rsp_code   (rsp_code),
    .rsp_repeat (rsp_repeat),
    .game_over  (game_over),
    .loser      (loser)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int         p, x, y, len, dir;
    int         lat;
    logic [1:0] code;
    bit         rep, go;
    int         loser, rem0;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] op, input int p, x, y, len, dir, lat,
                              input logic [1:0] code, input bit rep, go,
                              input int los, rem0);
    vec_t v;
    v.op = op; v.p = p; v.x = x; v.y = y; v.len = len; v.dir = dir;
    v.lat = lat; v.code = code; v.rep = rep; v.go = go; v.loser = los; v.rem0 = rem0;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cmd_op     = v.op;
    cmd_player = PLAYER_W'(v.p);
    cmd_x      = COORD_W'(v.x);
    cmd_y      = COORD_W'(v.y);
    cmd_len    = LEN_W'(v.len);
    cmd_dir    = v.dir[0];
    cmd_valid  = 1'b1;
  endtask

  // Called and returns at a negedge.
  task automatic run_vec(input vec_t v, input string nm);
    int lat, guard;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_ready"}, int'(cmd_ready), 1);
    drive(v);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 200);
    chk({nm, "_latency"}, lat, v.lat);
    chk({nm, "_code"},    int'(rsp_code), int'(v.code));
    chk({nm, "_repeat"},  int'(rsp_repeat), int'(v.rep));
    chk({nm, "_gameover"}, int'(game_over), int'(v.go));
    chk({nm, "_loser"},   int'(loser), v.loser);
    chk({nm, "_rem0"},    int'(dut.remaining[0]), v.rem0);
    @(negedge clk);
    chk({nm, "_strobe1"}, int'(rsp_valid), 0);
    chk({nm, "_readyback"}, int'(cmd_ready), 1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"},   int'(cmd_ready), 1);
    chk({nm, "_rspv"},    int'(rsp_valid), 0);
    chk({nm, "_code"},    int'(rsp_code), 0);
    chk({nm, "_repeat"},  int'(rsp_repeat), 0);
    chk({nm, "_gameover"}, int'(game_over), 0);
    chk({nm, "_loser"},   int'(loser), 0);
    chk({nm, "_rem0"},    int'(dut.remaining[0]), 0);
    chk({nm, "_rem1"},    int'(dut.remaining[1]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // op  p  x  y  len dir lat code rep go loser rem0
    vecs.push_back(mk(2'b00, 0, 2, 3, 3, 0,  7, OK,           0, 0, 0, 3));
    vecs.push_back(mk(2'b00, 0, 3, 1, 3, 1,  4, REJ,          0, 0, 0, 3));
    vecs.push_back(mk(2'b00, 1, 6, 0, 3, 0,  1, REJ,          0, 0, 0, 3));
    vecs.push_back(mk(2'b11, 0, 0, 0, 1, 0,  1, REJ,          0, 0, 0, 3));
    vecs.push_back(mk(2'b00, 1, 0, 0, 0, 0,  1, REJ,          0, 0, 0, 3));
    vecs.push_back(mk(2'b00, 1, 0, 0, 5, 0,  1, REJ,          0, 0, 0, 3));
    vecs.push_back(mk(2'b00, 1, 7, 4, 4, 1,  9, OK,           0, 0, 0, 3));
    vecs.push_back(mk(2'b01, 0, 3, 1, 0, 0,  2, MS,           0, 0, 0, 3));
    vecs.push_back(mk(2'b01, 0, 2, 3, 0, 0,  2, HT,           0, 0, 0, 2));
    vecs.push_back(mk(2'b01, 0, 2, 3, 0, 0,  2, EXP_REP_HIT,  1, 0, 0, 2));
    vecs.push_back(mk(2'b01, 0, 3, 1, 0, 0,  2, EXP_REP_MISS, 1, 0, 0, 2));
    vecs.push_back(mk(2'b01, 0, 3, 3, 0, 0,  2, HT,           0, 0, 0, 1));
    vecs.push_back(mk(2'b01, 0, 4, 3, 0, 0,  2, HT,           0, 1, 0, 0));
    vecs.push_back(mk(2'b01, 1, 7, 4, 0, 0,  1, REJ,          0, 1, 0, 0));
    vecs.push_back(mk(2'b00, 1, 0, 0, 1, 0,  1, REJ,          0, 1, 0, 0));
    vecs.push_back(mk(2'b10, 0, 0, 0, 0, 0, 65, OK,           0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 0, 2, 3, 0, 0,  2, MS,           0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 7, 4, 0, 0,  2, HT,           0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 7, 5, 0, 0,  2, HT,           0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 7, 6, 0, 0,  2, HT,           0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 7, 7, 0, 0,  2, HT,           0, 1, 1, 0));
    vecs.push_back(mk(2'b10, 1, 0, 0, 0, 0, 65, OK,           0, 0, 0, 0));
    vecs.push_back(mk(2'b01, 1, 7, 4, 0, 0,  2, MS,           0, 0, 0, 0));
    vecs.push_back(mk(2'b00, 0, 4, 0, 4, 0,  9, OK,           0, 0, 0, 4));

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("por_release");

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));
    chk("p1_remaining_end", int'(dut.remaining[1]), 0);

    // Reset during WRITE of a len-4 PLACE: CHECK covers cycles 1..4, WRITE 5..8.
    drive(mk(2'b00, 0, 0, 1, 4, 0, 0, OK, 0, 0, 0, 0));
    @(posedge clk);
    repeat (6) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("midwr_busy", int'(cmd_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midwr_inreset");
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midwr_no_response", seen, 0);
    chk_reset_outputs("midwr_after");
    // Both the aborted cells and the earlier ship must be EMPTY again.
    run_vec(mk(2'b00, 0, 0, 1, 4, 0, 9, OK, 0, 0, 0, 4), "replace_row1");
    run_vec(mk(2'b00, 0, 4, 0, 4, 0, 9, OK, 0, 0, 0, 8), "replace_row0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
